// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, destination-tag width, shift-op encodings
// and the operand record that travels through stage 1 of the shift pipeline.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] amount;
    logic [1:0]        op;
    logic [TAG_W-1:0]  tag;
  } s1_entry_t;

  // Any amount of DATA_W or more empties a word, so saturate at DATA_W.
  function automatic logic [4:0] clamp_amount(input logic [DATA_W-1:0] amount);
    return (amount > DATA_W[DATA_W-1:0]) ? 5'd16 : amount[4:0];
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 16-bit shifter: logical left/right, arithmetic right and rotate
// right, producing the result and the last bit shifted out.
module shift_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] amount_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic              over_width;
  logic [4:0]        amt;
  logic [3:0]        rot;
  logic [DATA_W:0]   lsl_w;
  logic [DATA_W:0]   lsr_w;
  logic [DATA_W:0]   asr_w;
  logic [DATA_W-1:0] ror_r;

  assign over_width = amount_i > DATA_W[DATA_W-1:0];
  assign amt        = clamp_amount(amount_i);
  assign rot        = amount_i[3:0];

  // One guard bit beside the word catches the last bit shifted out.
  assign lsl_w = {1'b0, data_i} << amt;
  assign lsr_w = {data_i, 1'b0} >> amt;
  assign asr_w = $signed({data_i, 1'b0}) >>> amt;
  assign ror_r = (data_i >> rot) | (data_i << (5'd16 - {1'b0, rot}));

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    result_o = data_i;
    carry_o  = 1'b0;
    case (op_i)
      SH_LSL: begin
        if (over_width) begin
          result_o = '0;
        end else begin
          result_o = lsl_w[DATA_W-1:0];
          carry_o  = lsl_w[DATA_W];
        end
      end
      SH_LSR: begin
        if (over_width) begin
          result_o = '0;
        end else begin
          {result_o, carry_o} = lsr_w;
        end
      end
      SH_ASR: begin
        {result_o, carry_o} = asr_w;
      end
      SH_ROR: begin
        result_o = ror_r;
        carry_o  = (rot != 4'd0) & ror_r[DATA_W-1];
      end
      default: begin
        result_o = data_i;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_stage.sv
// Two-stage valid/ready shift pipeline: S1 holds accepted operands, S2 holds
// result, tag and flags. Flag outputs exist only when SHIFT_STAGE_FLAGS_EN is defined.
module shift_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_shift,
  input  logic [1:0]        in_control,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_carry,
  output logic [1:0]        occupancy
);

  s1_entry_t         s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              s2_load;
  logic [DATA_W-1:0] core_result;
  logic              core_carry;

  shift_core u_shift_core (
    .data_i   (s1_q.data),
    .amount_i (s1_q.amount),
    .op_i     (s1_q.op),
    .result_o (core_result),
    .carry_o  (core_carry)
  );

  // NOTE: combinational next-state logic uses blocking '=' so later lines see
  // earlier results; the always_ff blocks below use non-blocking '<=' only.
  always_comb begin
    s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready   = !s1_valid_q || s2_load;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = '{data: in_data, amount: in_shift, op: in_control, tag: in_tag};
      end
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    tag_d      = tag_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = core_result;
      tag_d      = s1_q.tag;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
    end
  end

  // NOTE: the S1 operand payload is never observed unless s1_valid_q is set,
  // so it is left out of reset and needs no reset network.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

`ifdef SHIFT_STAGE_FLAGS_EN
  logic zero_q, neg_q, carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (s2_load && !flush) begin
      zero_q  <= (core_result == '0);
      neg_q   <= core_result[DATA_W-1];
      carry_q <= core_carry;
    end
  end

  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign out_carry = carry_q;
`else
  logic flags_unused;
  assign flags_unused = core_carry;
  assign out_zero     = 1'b0;
  assign out_neg      = 1'b0;
  assign out_carry    = 1'b0;
`endif

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign occupancy  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: flush  input  1  synchronous pipeline clear.
REQ-004 SHALL have ports: in_valid input 1; in_ready output 1; upstream handshake.
REQ-005 SHALL have ports: in_data input 16 operand; in_shift input 16 amount; in_control input 2 op; in_tag input 3 destination register.
REQ-006 SHALL have ports: out_valid output 1; out_ready input 1; downstream handshake.
REQ-007 SHALL have ports: out_result output 16; out_tag output 3; out_zero, out_neg, out_carry output 1 each.
REQ-008 SHALL have port: occupancy  output  2  entries held, range 0..2.

Function
REQ-009 SHALL be a two-stage pipeline: S1 registers accepted operands; S2 registers result, tag and flags.
REQ-010 SHALL transfer a word on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-011 SHALL load S2 when S1 holds a valid entry and (S2 is empty or out_ready=1).
REQ-012 SHALL assert in_ready = !S1_valid || S2-load condition, combinationally; out_valid = S2_valid.
REQ-013 SHALL give 2-cycle latency, accept-to-out_valid, with 1 word/cycle sustained throughput when out_ready=1.
REQ-014 SHALL hold out_result, out_tag and flags stable while out_valid=1 and out_ready=0.
REQ-015 SHALL encode in_control: 00 logical left; 01 logical right; 10 arithmetic right; 11 rotate right.
REQ-016 SHALL, for in_shift >= 16: give 0 for 00/01; fill with in_data[15] for 10; use in_shift[3:0] for 11.
REQ-017 SHALL pass in_data unchanged when in_shift=0, for every op.
REQ-018 SHALL set out_zero = (result==0) and out_neg = result[15].
REQ-019 SHALL set out_carry to the last bit shifted out, as follows:
 - 00: in_data[16-n] for n in 1..16.
 - 01/10: in_data[n-1] for n in 1..16.
 - 10 with n > 16: in_data[15].
 - 11: result[15] when n[3:0] != 0.
 - all other cases: 0.
REQ-020 SHALL, on flush=1, clear S1_valid and S2_valid at the next edge and ignore any same-cycle input handshake.
REQ-021 SHALL, when flush and a stall coincide, let flush win; datapath registers may keep stale values.
REQ-022 SHALL report occupancy = S1_valid + S2_valid.

Reset
REQ-023 SHALL, while rst=1, asynchronously clear S1_valid, S2_valid, out_result, out_tag, all flags and occupancy to 0.
REQ-024 SHALL drop any entry in flight when rst asserts mid-operation; in_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-025 SHALL compile flag generation in only when SHIFT_STAGE_FLAGS_EN is defined.
REQ-026 SHALL, when SHIFT_STAGE_FLAGS_EN is undefined, tie out_zero, out_neg and out_carry to 0 and omit their registers; the port list is unchanged.

Structure
REQ-027 SHALL take the shift-op encoding constants (SH_LSL, SH_LSR, SH_ASR, SH_ROR) and the 16-bit data width from a shared package, alu_pkg.
REQ-028 SHALL instantiate a combinational sub-module, shift_core, for result and carry computation between S1 and S2.

Verification
REQ-029 SHALL cover: data=0x8001, shift=1, ctl=00, ready=1 -> result 0x0002, carry 1, out_valid 2 cycles after accept.
REQ-030 SHALL cover: data=0x8000, shift=20, ctl=10 -> result 0xFFFF, neg 1, carry 1.
REQ-031 SHALL cover: data=0x1234, shift=4, ctl=11 -> result 0x4123, carry 0; and shift=0 -> result 0x1234, carry 0.
REQ-032 SHALL cover: out_ready held 0 with 3 words offered -> 2 accepted, occupancy 2, in_ready 0, outputs stable; release -> words emerge in order.
REQ-033 SHALL cover: flush while occupancy=2 -> next cycle occupancy 0, out_valid 0, flushed tags never appear.
REQ-034 SHALL cover: rst pulse mid-stream -> out_valid drops immediately, with no edge required; post-reset first word has 2-cycle latency.
